// File: rtl/mcu_pkg.sv
// Shared constants and FSM state type for the MCU SPI bridge.
package mcu_pkg;

  localparam int unsigned TARGET_SYS          = 0;
  localparam int unsigned TARGET_HID          = 1;
  localparam int unsigned TARGET_OSD          = 2;
  localparam int unsigned TARGET_SDC          = 3;
  localparam int unsigned NUM_TARGETS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TARGET,
    ST_CMD,
    ST_DATA
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin plus registered edge detect.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcu_spi_bridge.sv
// SPI mode-0 target: first byte selects a target, later bytes are strobed to it,
// and the selected target's reply byte is shifted back one byte later.
module mcu_spi_bridge
  import mcu_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = NUM_TARGETS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_io_ss,
  input  logic                     spi_io_clk,
  input  logic                     spi_io_din,
  output logic                     spi_io_dout,
  output logic [NUM_TARGETS-1:0]   data_strobe,
  output logic                     data_start,
  output logic [7:0]               data_out,
  input  logic [8*NUM_TARGETS-1:0] data_in,
  output state_t                   debug_state
);

  logic ss_level, ss_rise, ss_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  // SS resets to "low" so a select already held low through reset never
  // produces a falling edge; a transaction needs SS to be seen high first.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_ss (
    .clk(clk), .reset(reset), .din(spi_io_ss),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .din(spi_io_clk),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(spi_io_din),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_t     state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] target_id;
  logic [7:0] tx_shift;
  logic [1:0] load_pipe;
  logic [7:0] reply;
  logic [7:0] byte_val;
  logic       active;
  logic       byte_done;
  logic       void_sel;
  logic       strobe_en;

  assign active    = (state_q != ST_IDLE);
  assign byte_done = active && sck_rise && (bit_cnt == 3'd7);
  assign byte_val  = {rx_shift[6:0], mosi_level};
  assign void_sel  = (32'(target_id) >= NUM_TARGETS);
  assign strobe_en = byte_done && !void_sel &&
                     ((state_q == ST_CMD) || (state_q == ST_DATA));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_fall)   state_d = ST_TARGET;
      ST_TARGET: if (byte_done) state_d = ST_CMD;
      ST_CMD:    if (byte_done) state_d = ST_DATA;
      ST_DATA:   state_d = ST_DATA;
      default:   state_d = ST_IDLE;
    endcase
    if (ss_level) state_d = ST_IDLE;
  end

  // Out-of-range target ids match nothing, so a void transaction replies 0.
  always_comb begin
    reply = 8'h00;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (32'(target_id) == i) reply = data_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      target_id   <= 8'h00;
      tx_shift    <= 8'h00;
      load_pipe   <= 2'b00;
      data_out    <= 8'h00;
      data_strobe <= '0;
      data_start  <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_pipe <= {load_pipe[0], byte_done};

      if (ss_level) begin
        bit_cnt <= 3'd0;
      end else if (active && sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= byte_val;
      end

      if (byte_done && (state_q == ST_TARGET)) target_id <= byte_val;

      data_start <= 1'b0;
      for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
        data_strobe[i] <= strobe_en && (32'(target_id) == i);
      end
      if (strobe_en) begin
        data_out   <= byte_val;
        data_start <= (state_q == ST_CMD);
      end

      // The fall closing a byte (bit_cnt back at 0) is skipped so the freshly
      // loaded MSB stays on MISO for the first rise of the next byte.
      if (ss_level || ss_fall) begin
        tx_shift  <= 8'h00;
        load_pipe <= 2'b00;
      end else if (load_pipe[1]) begin
        tx_shift <= reply;
      end else if (active && sck_fall && (bit_cnt != 3'd0)) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_io_dout = tx_shift[7];
  assign debug_state = state_q;

endmodule
